// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA exponentiation scheduler.
package rsa_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_ENC = 2'b11;
    localparam logic [1:0] MODE_DEC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_SQUARE,
        ST_MULT,
        ST_DONE,
        ST_ERR
    } state_e;

    // Any mode with bit 1 set that is not encrypt falls back to the private exponent.
    function automatic logic [WIDTH-1:0] sel_exp(input logic [1:0]       mode,
                                                 input logic [WIDTH-1:0] e_key,
                                                 input logic [WIDTH-1:0] d_key);
        return (mode == MODE_ENC) ? e_key : d_key;
    endfunction

endpackage

// File: rtl/crypt_scheduler.sv
// Left-to-right square-and-multiply sequencer for msg^k mod n, driving a
// shared external modular multiplier through the mm_* handshake.
module crypt_scheduler
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] n_key,
    input  logic [WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0] d_key,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    output logic             mm_clr,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    state_e           state_q;
    logic [WIDTH-1:0] m_q, n_q, k_q, acc_q;
    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] i_d;
    logic             last_bit;
    logic             busy_q, done_q, error_q;
    logic [WIDTH-1:0] result_q;
    logic             mm_start_q, mm_clr_q;
    logic [WIDTH-1:0] mm_a_q, mm_b_q, mm_n_q;

    assign i_d      = i_q - IDX_W'(1);
    assign last_bit = (i_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            i_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            result_q   <= '0;
            mm_start_q <= 1'b0;
            mm_clr_q   <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_n_q     <= '0;
        end else begin
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            mm_clr_q   <= 1'b0;

            if (abort && state_q != ST_IDLE) begin
                // Only a multiplier that may hold an operation in flight needs clearing.
                mm_clr_q <= (state_q == ST_SQUARE) || (state_q == ST_MULT);
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && mode[1]) begin
                            m_q     <= msg;
                            n_q     <= n_key;
                            k_q     <= sel_exp(mode, e_key, d_key);
                            i_q     <= IDX_W'(WIDTH - 1);
                            error_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_CHECK;
                        end
                    end

                    ST_CHECK: begin
                        if (n_q < WIDTH'(2) || m_q >= n_q) begin
                            state_q <= ST_ERR;
                        end else if (k_q == '0) begin
                            acc_q   <= WIDTH'(1);
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SCAN;
                        end
                    end

                    ST_SCAN: begin
                        if (k_q[i_q]) begin
                            acc_q <= m_q;
                            if (last_bit) begin
                                state_q <= ST_DONE;
                            end else begin
                                i_q        <= i_d;
                                mm_start_q <= 1'b1;
                                mm_a_q     <= m_q;
                                mm_b_q     <= m_q;
                                mm_n_q     <= n_q;
                                state_q    <= ST_SQUARE;
                            end
                        end else begin
                            i_q <= i_d;
                        end
                    end

                    ST_SQUARE: begin
                        if (mm_done) begin
                            acc_q <= mm_result;
                            if (k_q[i_q]) begin
                                mm_start_q <= 1'b1;
                                mm_a_q     <= mm_result;
                                mm_b_q     <= m_q;
                                state_q    <= ST_MULT;
                            end else if (last_bit) begin
                                state_q <= ST_DONE;
                            end else begin
                                i_q        <= i_d;
                                mm_start_q <= 1'b1;
                                mm_a_q     <= mm_result;
                                mm_b_q     <= mm_result;
                            end
                        end
                    end

                    ST_MULT: begin
                        if (mm_done) begin
                            acc_q <= mm_result;
                            if (last_bit) begin
                                state_q <= ST_DONE;
                            end else begin
                                i_q        <= i_d;
                                mm_start_q <= 1'b1;
                                mm_a_q     <= mm_result;
                                mm_b_q     <= mm_result;
                                state_q    <= ST_SQUARE;
                            end
                        end
                    end

                    ST_DONE: begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end

                    ST_ERR: begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end

                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mm_start = mm_start_q;
    assign mm_clr   = mm_clr_q;
    assign mm_a     = mm_a_q;
    assign mm_b     = mm_b_q;
    assign mm_n     = mm_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign result   = result_q;

endmodule

// File: tb/tb_crypt_scheduler.sv
// Directed bench for crypt_scheduler with a behavioural modular multiplier.
module tb_crypt_scheduler;
    import rsa_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] msg = '0, n_key = '0, e_key = '0, d_key = '0;
    logic        mm_start, mm_clr, mm_done;
    logic [31:0] mm_a, mm_b, mm_n, mm_result;
    logic        busy, done, error;
    logic [31:0] result;

    always #5 clk = ~clk;

    crypt_scheduler dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .abort(abort),
        .msg(msg), .n_key(n_key), .e_key(e_key), .d_key(d_key),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
        .mm_clr(mm_clr), .mm_done(mm_done), .mm_result(mm_result),
        .busy(busy), .done(done), .error(error), .result(result)
    );

    // Multiplier model with programmable latency; inj_* lets the bench force a stray done.
    int          lat = 3;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] ma = '0, mb = '0, mn = '0;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_res = '0;
    logic        inj_done = 1'b0;
    logic [31:0] inj_res = '0;

    assign mm_done   = mdl_done | inj_done;
    assign mm_result = inj_done ? inj_res : mdl_res;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!rst || mm_clr) begin
            pend <= 1'b0;
        end else if (mm_start) begin
            pend <= 1'b1;
            cnt  <= lat;
            ma   <= mm_a;
            mb   <= mm_b;
            mn   <= mm_n;
        end else if (pend) begin
            if (cnt == 0) begin
                pend     <= 1'b0;
                mdl_done <= 1'b1;
                mdl_res  <= 32'((64'(ma) * 64'(mb)) % 64'(mn));
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    int mm_tot = 0, done_tot = 0, clr_tot = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (mm_start) mm_tot   <= mm_tot + 1;
            if (done)     done_tot <= done_tot + 1;
            if (mm_clr)   clr_tot  <= clr_tot + 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Runs one operation; poke>=0 fires an extra start (msg=5) that many cycles in.
    task automatic run_op(input logic [1:0] md, input logic [31:0] ms, nk, ek, dk,
                          input int poke,
                          output logic [31:0] r, output logic er, output int mmc,
                          output int dnc, output logic bsy1, output logic ok,
                          output logic dn_after);
        int mm0, dn0;
        @(negedge clk);
        mode = md; msg = ms; n_key = nk; e_key = ek; d_key = dk; start = 1'b1;
        mm0 = mm_tot; dn0 = done_tot;
        @(negedge clk);
        start = 1'b0;
        bsy1  = busy;
        ok    = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (c == poke) begin
                start = 1'b1;
                msg   = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        r  = result;
        er = error;
        @(negedge clk);
        dn_after = done;
        mmc = mm_tot - mm0;
        dnc = done_tot - dn0;
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  md;
        logic [31:0] ms, nk, ek, dk, res;
        logic        err;
        int          mm;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [31:0] r, prev_res;
        logic        er, bsy1, ok, dn_after, prev_err, seen;
        int          mmc, dnc, clr0, dn0, mm0;

        vt[0]  = '{"enc",      2'b11, 32'd65,   32'd3233, 32'd17,          32'd2753, 32'd2790, 1'b0, 5};
        vt[1]  = '{"bad_m",    2'b11, 32'd3233, 32'd3233, 32'd17,          32'd2753, 32'd0,    1'b1, 0};
        vt[2]  = '{"dec",      2'b10, 32'd2790, 32'd3233, 32'd17,          32'd2753, 32'd65,   1'b0, 15};
        vt[3]  = '{"n_one",    2'b11, 32'd0,    32'd1,    32'd3,           32'd3,    32'd0,    1'b1, 0};
        vt[4]  = '{"exp0",     2'b11, 32'd5,    32'd3233, 32'd0,           32'd7,    32'd1,    1'b0, 0};
        vt[5]  = '{"exp1",     2'b11, 32'd5,    32'd3233, 32'd1,           32'd7,    32'd5,    1'b0, 0};
        vt[6]  = '{"dec_d2",   2'b10, 32'd10,   32'd3233, 32'd17,          32'd2,    32'd100,  1'b0, 1};
        vt[7]  = '{"pow8",     2'b11, 32'd3,    32'd1000, 32'd8,           32'd1,    32'd561,  1'b0, 3};
        vt[8]  = '{"n_two",    2'b11, 32'd1,    32'd2,    32'd5,           32'd1,    32'd1,    1'b0, 3};
        vt[9]  = '{"m_max",    2'b11, 32'd3232, 32'd3233, 32'd2,           32'd1,    32'd1,    1'b0, 1};
        vt[10] = '{"bit31",    2'b11, 32'd1,    32'd3233, 32'h8000_0000,   32'd1,    32'd1,    1'b0, 31};

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_mm_start", 32'(mm_start), 0);
        chk("rst_mm_clr", 32'(mm_clr), 0);
        chk("rst_result", result, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        chk("rst_mm_n", mm_n, 0);
        rst = 1'b1;

        for (int v = 0; v < 11; v++) begin
            run_op(vt[v].md, vt[v].ms, vt[v].nk, vt[v].ek, vt[v].dk, -1,
                   r, er, mmc, dnc, bsy1, ok, dn_after);
            chk({vt[v].nm, "_finished"}, 32'(ok), 1);
            chk({vt[v].nm, "_busy1"}, 32'(bsy1), 1);
            chk({vt[v].nm, "_result"}, r, vt[v].res);
            chk({vt[v].nm, "_error"}, 32'(er), 32'(vt[v].err));
            chk({vt[v].nm, "_mm_cnt"}, 32'(mmc), 32'(vt[v].mm));
            chk({vt[v].nm, "_done_cnt"}, 32'(dnc), 1);
            chk({vt[v].nm, "_done_1cyc"}, 32'(dn_after), 0);
        end

        // Second start while busy must not disturb the running operation.
        run_op(2'b11, 32'd65, 32'd3233, 32'd17, 32'd2753, 3, r, er, mmc, dnc, bsy1, ok, dn_after);
        chk("restart_finished", 32'(ok), 1);
        chk("restart_result", r, 32'd2790);
        chk("restart_mm_cnt", 32'(mmc), 5);
        chk("restart_done_cnt", 32'(dnc), 1);

        // Mode 01 must not start anything.
        @(negedge clk);
        mode = 2'b01; msg = 32'd65; n_key = 32'd3233; e_key = 32'd17; start = 1'b1;
        mm0 = mm_tot; dn0 = done_tot;
        @(negedge clk);
        start = 1'b0;
        chk("mode01_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        chk("mode01_done_cnt", 32'(done_tot - dn0), 0);
        chk("mode01_mm_cnt", 32'(mm_tot - mm0), 0);
        chk("mode01_result", result, 32'd2790);

        // Abort while the multiplier is stalled in SQUARE, then a stray mm_done.
        lat = 1000;
        prev_res = result; prev_err = error;
        @(negedge clk);
        mode = 2'b11; msg = 32'd65; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (mm_start) seen = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reached_square", 32'(seen), 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        clr0 = clr_tot; dn0 = done_tot;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_mm_clr", 32'(mm_clr), 1);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        chk("abort_mm_clr_1cyc", 32'(mm_clr), 0);
        chk("abort_clr_cnt", 32'(clr_tot - clr0), 1);
        lat = 3;
        mm0 = mm_tot;
        inj_res = 32'd777; inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_done_result", result, prev_res);
        chk("late_done_error", 32'(error), 32'(prev_err));
        chk("late_done_busy", 32'(busy), 0);
        chk("late_done_done_cnt", 32'(done_tot - dn0), 0);
        chk("late_done_mm_cnt", 32'(mm_tot - mm0), 0);

        // Reset mid-operation clears everything on the next edge.
        @(negedge clk);
        mode = 2'b11; msg = 32'd65; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (mm_start) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_reached_square", 32'(seen), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_error", 32'(error), 0);
        chk("rst_mid_mm_start", 32'(mm_start), 0);
        chk("rst_mid_mm_clr", 32'(mm_clr), 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_mm_a", mm_a, 0);
        chk("rst_mid_mm_b", mm_b, 0);
        chk("rst_mid_mm_n", mm_n, 0);
        rst = 1'b1;

        run_op(2'b10, 32'd2790, 32'd3233, 32'd17, 32'd2753, -1, r, er, mmc, dnc, bsy1, ok, dn_after);
        chk("recover_finished", 32'(ok), 1);
        chk("recover_result", r, 32'd65);
        chk("recover_mm_cnt", 32'(mmc), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
